// File: rtl/rocc_mem_seq.sv
// rocc_mem_seq: RoCC command sequencer.
// Turns one SUM instruction into a series of 64-bit L1 loads. It issues one
// load at a time, replays a load when the cache nacks it, sums the returned
// words and writes the sum back to rd.
// Ports:
//   clock, reset              - single clock, synchronous active-high reset
//   rocc_cmd_*                - core command channel (funct, rd, xd, rs1=base, rs2=count)
//   rocc_resp_*               - core response channel (rd, data)
//   rocc_mem_req_*            - cache load request (addr, tag, cmd/size/signed constants)
//   rocc_mem_s2_nack          - cache nack of the outstanding request
//   rocc_mem_resp_*           - cache load response (tag, data)
//   rocc_busy, rocc_interrupt - status (interrupt is tied low)
// Optional feature: define ROCC_MEM_SEQ_PERF_EN to add a REQ/WAIT cycle
// counter that funct 1 reads back (and clears on the response handshake).
module rocc_mem_seq #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned TAG_W  = 9,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              rocc_cmd_ready,
  input  logic              rocc_cmd_valid,
  input  logic [6:0]        rocc_cmd_bits_inst_funct,
  input  logic [4:0]        rocc_cmd_bits_inst_rd,
  input  logic              rocc_cmd_bits_inst_xd,
  input  logic [XLEN-1:0]   rocc_cmd_bits_rs1,
  input  logic [XLEN-1:0]   rocc_cmd_bits_rs2,
  input  logic              rocc_resp_ready,
  output logic              rocc_resp_valid,
  output logic [4:0]        rocc_resp_bits_rd,
  output logic [XLEN-1:0]   rocc_resp_bits_data,
  input  logic              rocc_mem_req_ready,
  output logic              rocc_mem_req_valid,
  output logic [ADDR_W-1:0] rocc_mem_req_bits_addr,
  output logic [TAG_W-1:0]  rocc_mem_req_bits_tag,
  output logic [4:0]        rocc_mem_req_bits_cmd,
  output logic [1:0]        rocc_mem_req_bits_size,
  output logic              rocc_mem_req_bits_signed,
  input  logic              rocc_mem_s2_nack,
  input  logic              rocc_mem_resp_valid,
  input  logic [TAG_W-1:0]  rocc_mem_resp_bits_tag,
  input  logic [XLEN-1:0]   rocc_mem_resp_bits_data,
  output logic              rocc_busy,
  output logic              rocc_interrupt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [4:0]          rd_q, rd_d;
  logic                xd_q, xd_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [XLEN-1:0]     acc_q, acc_d;

`ifdef ROCC_MEM_SEQ_PERF_EN
  localparam int unsigned PERF_W = CNT_W + 16;
  logic [PERF_W-1:0]   perf_q, perf_d;
  logic                perf_clr_q, perf_clr_d;
`endif

  logic [CNT_W-1:0]    cmd_cnt;
  logic                cmd_is_sum;
  logic                tag_hit;
  logic                unused_bits;

  assign cmd_cnt    = rocc_cmd_bits_rs2[CNT_W-1:0];
  assign cmd_is_sum = (rocc_cmd_bits_inst_funct == 7'd0);
  assign tag_hit    = (rocc_mem_resp_bits_tag == TAG_W'(idx_q));
  // Upper operand bits are architecturally ignored.
  assign unused_bits = ^{rocc_cmd_bits_rs1[XLEN-1:ADDR_W], rocc_cmd_bits_rs2[XLEN-1:CNT_W]};

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    xd_d    = xd_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
`ifdef ROCC_MEM_SEQ_PERF_EN
    perf_clr_d = perf_clr_q;
    perf_d     = perf_q;
    // Saturating count of cycles spent sequencing memory traffic.
    if ((state_q == S_REQ || state_q == S_WAIT) && !(&perf_q)) begin
      perf_d = perf_q + PERF_W'(1);
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (rocc_cmd_valid) begin
          rd_d   = rocc_cmd_bits_inst_rd;
          xd_d   = rocc_cmd_bits_inst_xd;
          base_d = rocc_cmd_bits_rs1[ADDR_W-1:0];
          cnt_d  = cmd_cnt;
          idx_d  = '0;
          acc_d  = '0;
          if (cmd_is_sum && cmd_cnt != '0) begin
            state_d = S_REQ;
          end else if (rocc_cmd_bits_inst_xd) begin
            state_d = S_RESP;
          end else begin
            state_d = S_IDLE;
          end
`ifdef ROCC_MEM_SEQ_PERF_EN
          perf_clr_d = (rocc_cmd_bits_inst_funct == 7'd1);
          if (cmd_is_sum) begin
            perf_d = '0;
          end
          // Counter readback travels through the accumulator.
          if (rocc_cmd_bits_inst_funct == 7'd1) begin
            acc_d = XLEN'(perf_q);
          end
`endif
        end
      end
      S_REQ: begin
        if (rocc_mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A nack replays the same word; nothing is accumulated.
        if (rocc_mem_s2_nack) begin
          state_d = S_REQ;
        end else if (rocc_mem_resp_valid && tag_hit) begin
          acc_d = acc_q + rocc_mem_resp_bits_data;
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == cnt_q - CNT_W'(1)) begin
            state_d = xd_q ? S_RESP : S_IDLE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_RESP: begin
        if (rocc_resp_ready) begin
          state_d = S_IDLE;
`ifdef ROCC_MEM_SEQ_PERF_EN
          if (perf_clr_q) begin
            perf_d = '0;
          end
          perf_clr_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      xd_q    <= 1'b0;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
`ifdef ROCC_MEM_SEQ_PERF_EN
      perf_q     <= '0;
      perf_clr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      xd_q    <= xd_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
`ifdef ROCC_MEM_SEQ_PERF_EN
      perf_q     <= perf_d;
      perf_clr_q <= perf_clr_d;
`endif
    end
  end

  // Outputs decode straight from registered state.
  assign rocc_cmd_ready           = (state_q == S_IDLE);
  assign rocc_busy                = (state_q != S_IDLE);
  assign rocc_mem_req_valid       = (state_q == S_REQ);
  assign rocc_mem_req_bits_addr   = base_q + (ADDR_W'(idx_q) << 3);
  assign rocc_mem_req_bits_tag    = TAG_W'(idx_q);
  assign rocc_mem_req_bits_cmd    = 5'd0;
  assign rocc_mem_req_bits_size   = 2'd3;
  assign rocc_mem_req_bits_signed = 1'b0;
  assign rocc_resp_valid          = (state_q == S_RESP);
  assign rocc_resp_bits_rd        = rd_q;
  assign rocc_resp_bits_data      = acc_q;
  assign rocc_interrupt           = 1'b0;

endmodule

// File: doc/rocc_mem_seq.md
Name: rocc_mem_seq

Overview:
- RoCC command sequencer that turns one custom instruction into a series of 64-bit L1 data-cache loads.
- Sums the returned words and writes the sum back to rd.
- Sits inside the accelerator top level, between the core's RoCC cmd/resp channels and the rocc_mem request/response channels.
- Owns all sequencing of the memory port: one outstanding load at a time, with replay on nack.

Parameters:
- XLEN, 64, data width of rs1/rs2/resp and mem data.
- ADDR_W, 40, memory address width (coreMaxAddrBits).
- TAG_W, 9, memory tag width (dcacheReqTagBits).
- CNT_W, 16, width of word-count field taken from rs2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rocc_cmd_ready  out  1  command accept.
- rocc_cmd_valid  in  1  command present.
- rocc_cmd_bits_inst_funct  in  7  operation select.
- rocc_cmd_bits_inst_rd  in  5  destination register.
- rocc_cmd_bits_inst_xd  in  1  response required.
- rocc_cmd_bits_rs1  in  XLEN  base address.
- rocc_cmd_bits_rs2  in  XLEN  word count (low CNT_W bits).
- rocc_resp_ready  in  1  core accepts response.
- rocc_resp_valid  out  1  response present.
- rocc_resp_bits_rd  out  5  destination register.
- rocc_resp_bits_data  out  XLEN  result.
- rocc_mem_req_ready  in  1  cache accepts request.
- rocc_mem_req_valid  out  1  request present.
- rocc_mem_req_bits_addr  out  ADDR_W  load address.
- rocc_mem_req_bits_tag  out  TAG_W  request tag.
- rocc_mem_req_bits_cmd  out  5  memory command, always 5'd0 (M_XRD).
- rocc_mem_req_bits_size  out  2  always 2'd3.
- rocc_mem_req_bits_signed  out  1  always 0.
- rocc_mem_s2_nack  in  1  request nacked, 2 cycles after fire.
- rocc_mem_resp_valid  in  1  load data valid.
- rocc_mem_resp_bits_tag  in  TAG_W  response tag.
- rocc_mem_resp_bits_data  in  XLEN  load data.
- rocc_busy  out  1  sequencer not idle.
- rocc_interrupt  out  1  tied 0.

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high. Reset forces state IDLE and clears idx, acc and all valid outputs; rocc_cmd_ready=1 after reset.
- States:
  - IDLE: rocc_cmd_ready=1.
  - REQ: rocc_mem_req_valid=1.
  - WAIT: awaiting load data or nack.
  - RESP: rocc_resp_valid=1.
- rocc_busy = (state != IDLE). rocc_cmd_ready = (state == IDLE).
- Command fire (IDLE, valid&ready): latch rd, xd, base=rs1[ADDR_W-1:0], count=rs2[CNT_W-1:0]; clear idx and acc.
  - funct 0 (SUM), count!=0 -> REQ.
  - funct 0, count==0 -> RESP with data 0 if xd, else IDLE.
  - Any other funct -> RESP with data 0 if xd, else IDLE. No memory traffic.
- REQ:
  - addr = base + (idx<<3), truncated to ADDR_W so it wraps modulo 2^ADDR_W.
  - tag = idx[TAG_W-1:0].
  - Outputs are held stable until rocc_mem_req_ready; on fire -> WAIT.
- WAIT:
  - rocc_mem_s2_nack=1 -> REQ with the same idx; acc unchanged.
  - rocc_mem_resp_valid with tag == idx[TAG_W-1:0]: acc <= acc + data (mod 2^XLEN); idx <= idx+1. If idx == count-1 -> RESP if xd, else IDLE; otherwise -> REQ.
  - A response whose tag does not match is ignored.
  - A response arriving in any state other than WAIT is ignored.
- RESP:
  - rocc_resp_bits_rd = latched rd; rocc_resp_bits_data = acc.
  - Held until rocc_resp_ready; then -> IDLE. Earliest next command accept is the following cycle.
- Latency per word: minimum 2 cycles (REQ fire + response in the next cycle), plus any cache delay.
- Reset mid-operation: immediate return to IDLE. Late mem responses or nacks are dropped. No response is issued for the aborted command.
- Count is unsigned: 0xFFFF means 65535 loads.

Optional Feature:
- Macro: ROCC_MEM_SEQ_PERF_EN.
- Defined:
  - A CNT_W+16-bit cycle counter increments every cycle the state is REQ or WAIT; it is cleared on each SUM command fire and saturates at all-ones.
  - funct 1 returns the counter value in RESP (zero-extended) and resets it to 0 on response handshake.
- Not defined: no counter logic; funct 1 behaves like any unknown funct and returns 0.

Test Plan:
- Reset then funct 0, rs1=0x1000, rs2=4, xd=1, rd=5; memory returns 1,2,3,4 with one-cycle response -> addrs 0x1000/0x1008/0x1010/0x1018, tags 0..3, resp rd=5 data=10.
- Same command with rocc_mem_req_ready low for 3 cycles on word 1 -> addr/tag held stable while low; final data=10.
- Nack on word 2 -> request reissued to 0x1010 with tag 2; no double add; data=10.
- rs2=0, xd=1 -> no mem_req_valid; resp data=0 one cycle after accept. funct 3 with xd=0 -> no resp; busy drops next cycle.
- Base 0xFF_FFFF_FFF8, count=2 -> second addr 0x00_0000_0000. Words 0xFFFF_FFFF_FFFF_FFFF + 2 -> data=1.
- Reset asserted in WAIT, then a stale resp with tag 0 -> ignored; busy=0, resp_valid=0. A new command then completes correctly.
